// File: rtl/rng_pkg.sv
// Shared types and constants for the round-robin random-number arbiter.
package rng_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } rng_state_t;

  // LFSR geometry and XNOR feedback taps.
  localparam int LFSR_W = 16;
  localparam int TAP_A  = 15;
  localparam int TAP_B  = 13;
  localparam int TAP_C  = 12;
  localparam int TAP_D  = 10;

  // Result range is 0..RESULT_MOD-1, carried on RESULT_W bits.
  localparam int RESULT_MOD = 100;
  localparam int RESULT_W   = 7;

  // Full-width unsigned modulo, truncated to the result bus width.
  function automatic logic [RESULT_W-1:0] result_of(input logic [LFSR_W-1:0] value);
    return RESULT_W'(value % LFSR_W'(RESULT_MOD));
  endfunction

endpackage

// File: rtl/lfsr16_core.sv
// 16-bit XNOR LFSR with parallel load; exposes both current and successor state.
module lfsr16_core
  import rng_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] next_state
);

  logic [LFSR_W-1:0] state_r;
  logic              feedback_s;

  // XNOR feedback; the all-zero state is a legal member of the sequence.
  always_comb begin
    feedback_s = ~(state_r[TAP_A] ^ state_r[TAP_B] ^ state_r[TAP_C] ^ state_r[TAP_D]);
    next_state = {state_r[LFSR_W-2:0], feedback_s};
  end

  // Shift register: load wins over step, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= {LFSR_W{1'b0}};
    end else if (load) begin
      state_r <= load_val;
    end else if (step) begin
      state_r <= next_state;
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one LFSR among N_REQ requesters via req/ack.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MIX_STEPS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req,
  input  logic                free_run,
  input  logic                seed_load,
  input  logic [LFSR_W-1:0]   seed,
  output logic [N_REQ-1:0]    ack,
  output logic [RESULT_W-1:0] number,
  output logic                busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MIX_STEPS + 1);

  rng_state_t          state_r, state_nxt_s;
  logic [PTR_W-1:0]    rr_ptr_r, rr_ptr_nxt_s;
  logic [PTR_W-1:0]    gnt_idx_r, gnt_idx_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [RESULT_W-1:0] number_r, number_nxt_s;
  logic [N_REQ-1:0]    ack_r, ack_nxt_s;
  logic                busy_r, busy_nxt_s;

  logic                lfsr_step_s;
  logic                lfsr_load_s;
  logic [LFSR_W-1:0]   lfsr_state_s;
  logic [LFSR_W-1:0]   lfsr_next_s;
  logic [LFSR_W-1:0]   lfsr_after_s;

  logic [PTR_W-1:0]    pick_idx_s;
  logic                pick_found_s;

  lfsr16_core u_lfsr (
    .clk        (clk),
    .reset_n    (reset_n),
    .step       (lfsr_step_s),
    .load       (lfsr_load_s),
    .load_val   (seed),
    .state      (lfsr_state_s),
    .next_state (lfsr_next_s)
  );

  // Round-robin pick: first asserted request at or after rr_ptr, wrapping.
  always_comb begin
    logic [PTR_W:0] pos;
    pick_idx_s   = {PTR_W{1'b0}};
    pick_found_s = 1'b0;
    pos          = {(PTR_W+1){1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      pos = {1'b0, rr_ptr_r} + (PTR_W+1)'(i);
      if (pos >= (PTR_W+1)'(N_REQ)) begin
        pos = pos - (PTR_W+1)'(N_REQ);
      end else begin
        pos = pos;
      end
      if (!pick_found_s && req[pos[PTR_W-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = pos[PTR_W-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Value the LFSR will hold after this edge; the result is taken from it.
  always_comb begin
    if (lfsr_step_s) begin
      lfsr_after_s = lfsr_next_s;
    end else begin
      lfsr_after_s = lfsr_state_s;
    end
  end

  // FSM next-state and next values for every registered output.
  always_comb begin
    state_nxt_s   = state_r;
    rr_ptr_nxt_s  = rr_ptr_r;
    gnt_idx_nxt_s = gnt_idx_r;
    cnt_nxt_s     = cnt_r;
    number_nxt_s  = number_r;
    ack_nxt_s     = {N_REQ{1'b0}};
    busy_nxt_s    = 1'b0;
    lfsr_step_s   = 1'b0;
    lfsr_load_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          gnt_idx_nxt_s = pick_idx_s;
          cnt_nxt_s     = {CNT_W{1'b0}};
          state_nxt_s   = MIX;
          busy_nxt_s    = 1'b1;
        end else if (seed_load) begin
          lfsr_load_s = 1'b1;
        end else if (free_run) begin
          lfsr_step_s = 1'b1;
        end else begin
          lfsr_step_s = 1'b0;
        end
      end
      MIX: begin
        lfsr_step_s = 1'b1;
        busy_nxt_s  = 1'b1;
        cnt_nxt_s   = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_W'(MIX_STEPS - 1)) begin
          number_nxt_s = result_of(lfsr_after_s);
          ack_nxt_s    = N_REQ'(1) << gnt_idx_r;
          state_nxt_s  = DONE;
        end else begin
          state_nxt_s  = MIX;
        end
      end
      DONE: begin
        // Move the pointer past the requester just served.
        if (gnt_idx_r == PTR_W'(N_REQ - 1)) begin
          rr_ptr_nxt_s = {PTR_W{1'b0}};
        end else begin
          rr_ptr_nxt_s = gnt_idx_r + PTR_W'(1);
        end
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any grant in flight without an ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      rr_ptr_r  <= {PTR_W{1'b0}};
      gnt_idx_r <= {PTR_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      number_r  <= {RESULT_W{1'b0}};
      ack_r     <= {N_REQ{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      rr_ptr_r  <= rr_ptr_nxt_s;
      gnt_idx_r <= gnt_idx_nxt_s;
      cnt_r     <= cnt_nxt_s;
      number_r  <= number_nxt_s;
      ack_r     <= ack_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  assign ack    = ack_r;
  assign number = number_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed plus randomized bench for rng_arbiter against a transaction-level model.
module tb_rng_arbiter;

  localparam int N_REQ     = 4;
  localparam int MIX_STEPS = 8;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic [3:0]  req       = 4'b0000;
  logic        free_run  = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed      = 16'h0000;
  logic [3:0]  ack;
  logic [6:0]  number;
  logic        busy;

  int          n_cmp  = 0;
  int          n_fail = 0;

  // Reference model: LFSR contents and round-robin pointer.
  logic [15:0] m_state = 16'h0000;
  int          m_ptr   = 0;
  logic [3:0]  last_ack;

  rng_arbiter #(.N_REQ(N_REQ), .MIX_STEPS(MIX_STEPS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .free_run  (free_run),
    .seed_load (seed_load),
    .seed      (seed),
    .ack       (ack),
    .number    (number),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = ~(s[15] ^ s[13] ^ s[12] ^ s[10]);
    return {s[14:0], fb};
  endfunction

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (p + i) % N_REQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = 4'b0000;
    free_run  = 1'b0;
    seed_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_number", 32'(number), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    m_state = 16'h0000;
    m_ptr   = 0;
  endtask

  task automatic idle(input int n, input bit fr, input bit sl, input logic [15:0] sv);
    free_run  = fr;
    seed_load = sl;
    seed      = sv;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (sl) m_state = sv;
      else if (fr) m_state = lfsr_next(m_state);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    free_run  = 1'b0;
    seed_load = 1'b0;
  endtask

  // One full transaction starting in IDLE; returns in IDLE one cycle after ack.
  task automatic grant(input logic [3:0] r, input logic [3:0] after_ack, input bit noise);
    int          win;
    int          cyc;
    bit          got;
    logic [15:0] exp_s;
    req   = r;
    win   = pick(r, m_ptr);
    exp_s = m_state;
    for (int k = 0; k < MIX_STEPS; k++) exp_s = lfsr_next(exp_s);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 3 * MIX_STEPS + 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ack != 4'b0000) begin
        got = 1'b1;
      end else begin
        chk("busy_mix", 32'(busy), 32'd1);
        if (noise && cyc == 2) begin
          seed_load = 1'b1;
          free_run  = 1'b1;
          seed      = 16'($urandom);
          req       = 4'b0000;
        end
        if (noise && cyc == 3) begin
          seed_load = 1'b0;
          free_run  = 1'b0;
        end
      end
    end
    last_ack = ack;
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(cyc), 32'(MIX_STEPS + 1));
    chk("ack_onehot", 32'(ack), 32'(1) << win);
    chk("number", 32'(number), 32'(exp_s % 16'd100));
    chk("busy_done", 32'(busy), 32'd1);
    req       = after_ack;
    seed_load = 1'b0;
    free_run  = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_fall", 32'(ack), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("number_hold", 32'(number), 32'(exp_s % 16'd100));
    m_state = exp_s;
    m_ptr   = (win + 1) % N_REQ;
  endtask

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_order [4];
    exp_order = '{0, 1, 0, 1};

    // Single grant from reset.
    do_reset();
    grant(4'b0010, 4'b0000, 1'b0);
    chk("single_ack1", 32'(last_ack), 32'h2);
    chk("single_num55", 32'(number), 32'd55);

    // Round-robin from reset.
    do_reset();
    grant(4'b0101, 4'b0100, 1'b0);
    chk("rr_first0", 32'(last_ack), 32'h1);
    chk("rr_num55", 32'(number), 32'd55);
    grant(4'b0100, 4'b0000, 1'b0);
    chk("rr_second2", 32'(last_ack), 32'h4);
    chk("rr_num8", 32'(number), 32'd8);

    // Seed load in IDLE, seed/free_run noise during MIX.
    idle(1, 1'b0, 1'b1, 16'h0000);
    grant(4'b1000, 4'b0000, 1'b1);
    chk("seed_ack3", 32'(last_ack), 32'h8);
    chk("seed_num55", 32'(number), 32'd55);

    // Held request alternates with a competing one.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      grant(4'b0011, (i == 3) ? 4'b0000 : 4'b0011, 1'b0);
      chk("held_order", 32'(last_ack), 32'(1) << exp_order[i]);
    end

    // Reset in the middle of MIX.
    do_reset();
    grant(4'b1000, 4'b0000, 1'b0);
    req = 4'b0001;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_number", 32'(number), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    req = 4'b0000;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("midrst_noack", 32'(ack), 32'd0);
    end
    reset_n = 1'b1;
    m_state = 16'h0000;
    m_ptr   = 0;
    grant(4'b0010, 4'b0000, 1'b0);
    chk("midrst_num55", 32'(number), 32'd55);

    // Free-run gathers entropy while idle.
    do_reset();
    idle(3, 1'b1, 1'b0, 16'h0000);
    grant(4'b0100, 4'b0000, 1'b0);
    chk("freerun_num47", 32'(number), 32'd47);

    // Randomized traffic.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        idle(int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 16'($urandom));
      end
      grant(4'($urandom_range(1, 15)), 4'b0000, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_arbiter.md
# rng_arbiter

Shares one 16-bit XNOR LFSR random-number source between `N_REQ` requesters using round-robin arbitration and a req/ack handshake. Each grant advances the LFSR `MIX_STEPS` times, then returns `state % 100` on a shared 7-bit bus. While idle the generator can free-run, so user-timed requests gather entropy. The block sits between game-logic consumers (dice, targets, delays) and the random source, replacing direct per-consumer LFSR instances.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `MIX_STEPS`, 8: LFSR advances per grant, 1..255.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input N_REQ: level request per requester.
- `free_run` input 1: when high in IDLE, the LFSR advances every cycle.
- `seed_load` input 1: when high in IDLE, `state <= seed` on that edge.
- `seed` input 16: seed value.
- `ack` output N_REQ: one-hot, one-cycle pulse; `number` is valid in the same cycle.
- `number` output 7: last result, 0..99; holds until the next ack.
- `busy` output 1: high in MIX and DONE.

## Operation
- **LFSR step:** `state <= {state[14:0], ~(state[15]^state[13]^state[12]^state[10])}`. The all-zero state is legal.
- **FSM IDLE:**
  - If any `req` is high, grant the first set bit at or after `rr_ptr` (wrapping), latch `gnt_idx`, clear the step counter and go to MIX.
  - Otherwise, `seed_load` loads `seed`; else `free_run` steps the LFSR; else `state` holds.
  - `seed_load` has priority over `free_run`.
  - The LFSR does not step on the grant edge itself.
- **FSM MIX:**
  - Step the LFSR every cycle and increment the counter.
  - On the step that makes the count equal `MIX_STEPS`, register `number <= next_state % 100`, assert `ack[gnt_idx]` and go to DONE.
- **FSM DONE:**
  - `ack` stays high for this cycle only.
  - Set `rr_ptr <= (gnt_idx+1) mod N_REQ`, then return to IDLE. The LFSR holds.
- **Arithmetic:** the modulo is a full 16-bit unsigned `% 100`, truncated to 7 bits, so results are always ≤ 99.
- **Handshake:**
  - `req` is a level signal that the requester drops after seeing `ack`.
  - If `req` is still high in the IDLE cycle after DONE, it counts as a new request. It is served only after other pending requesters, because `rr_ptr` has moved past it.
- **Boundary conditions:**
  - Requester drops `req` during MIX: the transaction still completes and `ack` still pulses.
  - `seed_load` or `free_run` during MIX or DONE: ignored.
  - Multiple simultaneous requests: strict round-robin from `rr_ptr`.
  - A requester is never starved: worst-case wait is `(N_REQ-1)*(MIX_STEPS+2)` cycles after its grant opportunity.
  - Counter wrap: the counter width is `$clog2(MIX_STEPS+1)`, and the counter never exceeds `MIX_STEPS`.
- **Reset:** `reset_n` low at any time, including mid-MIX, forces:
  - `state` = 0, FSM = IDLE, `rr_ptr` = 0, counter = 0
  - `ack` = 0, `number` = 0, `busy` = 0
  - No ack is issued for an aborted grant.

## Timing
- Let E0 be the IDLE edge that samples a request.
- MIX occupies edges E1..E_MIX_STEPS. `ack` and the new `number` appear after edge E_MIX_STEPS.
- `ack` falls after E_MIX_STEPS+1.
- Request-to-ack latency is `MIX_STEPS` cycles; throughput is one grant per `MIX_STEPS+2` cycles.
- `busy` rises after E0 and falls after E_MIX_STEPS+1.
- All outputs are registered; there is no combinational path from `req` to `ack`.

## Structure
- **Package `rng_pkg`:**
  - FSM state enum `rng_state_t` {IDLE, MIX, DONE}
  - LFSR width 16 and tap constants
  - `RESULT_MOD` = 100
- **Sub-module `lfsr16_core`:**
  - Ports: `clk`, `reset_n`, `step`, `load`, `load_val`, `state`, `next_state`.
  - Owns the shift register and the XNOR feedback.
  - The arbiter owns the FSM, round-robin pointer, counter and the modulo register.

## Test plan
All scenarios use `MIX_STEPS`=8, `N_REQ`=4.
- **Single grant:** reset, `free_run`=0, pulse `req[1]` → `ack[1]` after 8 cycles with `number`=55 (state 0x00FF); `busy` high for 9 cycles.
- **Round-robin from reset:** `req[0]` and `req[2]` high together, each dropped on its own ack → `ack[0]` with `number`=55, then `ack[2]` with `number`=8 (state 0xFFE4).
- **Seed load and hold:** `seed_load` with `seed`=0x0000 in IDLE, then `req[3]` → `number`=55. `seed_load` pulsed during MIX → no effect on the result.
- **Held request:** `req[0]` held continuously while `req[1]` is also high → grant order 0, 1, 0, 1. No requester is granted twice in a row while another is pending.
- **Reset mid-MIX:** assert `reset_n`=0 at the 4th MIX cycle → no ack, `number`=0, `busy`=0. A re-request after release yields 55.
- **Free-run:** `free_run`=1 for 3 idle cycles after reset (state 7), then `req[2]` → 8 more steps give state 0x07FF, `number`=47.
